// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: load-use and branch-operand stalls, IF/ID flush on taken control transfer.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic        UsesRsD,
   input  logic        UsesRtD,
   input  logic        BranchD,
   input  logic [4:0]  WriteRegE,
   input  logic        RegWriteE,
   input  logic        MemReadE,
   input  logic [4:0]  WriteRegM,
   input  logic        MemReadM,
   input  logic        BranchTakenD,
   input  logic        JumpD,
   output logic        PCWriteEn,
   output logic        IFIDWriteEn,
   output logic        Decode_On,
   output logic        FlushIFID,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);

   typedef enum logic {RUN, STALL} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic [1:0] cnt_next;
   logic [1:0] hazard_len;
   logic       stall;
   logic       match_e;
   logic       match_m;

   // Register zero is hardwired, so it never creates a dependency.
   assign match_e = (UsesRsD && (RsD != 5'd0) && (RsD == WriteRegE)) ||
                    (UsesRtD && (RtD != 5'd0) && (RtD == WriteRegE));
   assign match_m = (UsesRsD && (RsD != 5'd0) && (RsD == WriteRegM)) ||
                    (UsesRtD && (RtD != 5'd0) && (RtD == WriteRegM));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      hazard_len = 2'd0;
      if (MemReadE && match_e) hazard_len = 2'd1;
      if (BranchD) begin
         if (RegWriteE && !MemReadE && match_e) hazard_len = 2'd1;
         if (MemReadM && match_m)               hazard_len = 2'd1;
         // A branch waiting on a load needs the loaded value two stages later.
         if (MemReadE && match_e)               hazard_len = 2'd2;
      end
   end

   always_comb begin
      state    = (cnt == 2'd0) ? RUN : STALL;
      stall    = 1'b0;
      cnt_next = cnt;
      unique case (state)
         RUN: begin
            if (hazard_len != 2'd0) begin
               stall    = 1'b1;
               cnt_next = hazard_len - 2'd1;
            end
         end
         STALL: begin
            stall    = 1'b1;
            cnt_next = cnt - 2'd1;
         end
      endcase

      PCWriteEn   = !stall;
      IFIDWriteEn = !stall;
      Decode_On   = !stall;
      FlushIFID   = (BranchTakenD || JumpD) && !stall;
      if (Reset) begin
         PCWriteEn   = 1'b1;
         IFIDWriteEn = 1'b1;
         Decode_On   = 1'b0;
         FlushIFID   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) cnt <= 2'd0;
      else       cnt <= cnt_next;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;
   logic        stalled;

   assign stalled = stall && !Reset;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (stalled && (stall_cnt_q != 16'hFFFF))   stall_cnt_q <= stall_cnt_q + 16'd1;
         if (FlushIFID && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`else
   assign StallCount = 16'd0;
   assign FlushCount = 16'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: Clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-003 SHALL have ports: RsD, RtD  input  5 each  source registers of the instruction in Decode.
REQ-004 SHALL have ports: UsesRsD, UsesRtD  input  1 each  Decode instruction reads Rs/Rt.
REQ-005 SHALL have port: BranchD  input  1  Decode instruction is a branch compared in Decode.
REQ-006 SHALL have ports: WriteRegE  input  5; RegWriteE, MemReadE  input  1  Execute-stage destination register and controls from the ID/EX register.
REQ-007 SHALL have ports: WriteRegM  input  5; MemReadM  input  1  Memory-stage destination register and load flag.
REQ-008 SHALL have ports: BranchTakenD, JumpD  input  1 each  control transfer resolved in Decode.
REQ-009 SHALL have ports: PCWriteEn, IFIDWriteEn  output  1  1 = PC / IF-ID register may update.
REQ-010 SHALL have port: Decode_On  output  1  0 = ID/EX register loads a bubble (all zero).
REQ-011 SHALL have port: FlushIFID  output  1  1 = IF/ID register is cleared at the next edge.
REQ-012 SHALL have ports: StallCount, FlushCount  output  16 each  performance counters.

Function
REQ-013 SHALL define matchE(r) = (r != 0) && (r == WriteRegE) and matchM(r) = (r != 0) && (r == WriteRegM), each qualified by the matching UsesRsD/UsesRtD.
REQ-014 SHALL detect load-use hazard: MemReadE && matchE(RsD or RtD) -> required stall length 1.
REQ-015 SHALL detect branch hazards when BranchD = 1: MemReadE && matchE -> length 2; RegWriteE && !MemReadE && matchE -> length 1; MemReadM && matchM -> length 1; the maximum applicable length wins.
REQ-016 SHALL hold a 2-bit stall counter Cnt; state RUN when Cnt = 0 and STALL when Cnt != 0.
REQ-017 In RUN with a hazard of length L detected, SHALL assert stall in the same cycle and load Cnt <= L-1 at the next edge.
REQ-018 In STALL, SHALL assert stall, ignore new hazard detection and decrement Cnt each cycle, returning to RUN when Cnt reaches 0.
REQ-019 While stall is asserted, SHALL drive PCWriteEn = 0, IFIDWriteEn = 0 and Decode_On = 0; otherwise all three are 1.
REQ-020 SHALL drive FlushIFID = (BranchTakenD || JumpD) && !stall; a flush SHALL never coincide with a stall.
REQ-021 All outputs except the counters SHALL be combinational from Cnt and the current inputs, with zero-cycle latency.
REQ-022 A hazard whose register index is 0 SHALL never stall.

Reset
REQ-023 On posedge Clk with Reset = 1, SHALL set Cnt <= 0, StallCount <= 0 and FlushCount <= 0.
REQ-024 While Reset = 1, SHALL drive PCWriteEn = 1, IFIDWriteEn = 1, Decode_On = 0 and FlushIFID = 0.
REQ-025 Reset asserted during STALL SHALL abandon the stall; the first cycle after deassertion SHALL be RUN.

Configuration
REQ-026 With macro HAZARD_PERF_CNT_EN defined, StallCount SHALL increment on every stalled cycle and FlushCount on every FlushIFID cycle, each saturating at 16'hFFFF.
REQ-027 Without HAZARD_PERF_CNT_EN, StallCount and FlushCount SHALL be constant 0 and no counter registers SHALL be synthesized; the ports remain present.

Verification
REQ-028 Load-use: MemReadE=1, WriteRegE=8, RsD=8, UsesRsD=1 -> exactly 1 cycle with PCWriteEn=0, IFIDWriteEn=0, Decode_On=0; then Cnt=0 and all three outputs are 1.
REQ-029 Branch after load: BranchD=1, MemReadE=1, WriteRegE=5, RtD=5, UsesRtD=1 -> 2 consecutive stall cycles, even if inputs change during the second cycle.
REQ-030 Register zero: MemReadE=1, WriteRegE=0, RsD=0 -> no stall; Decode_On stays 1.
REQ-031 Flush suppression: BranchTakenD=1 during a stall -> FlushIFID=0; BranchTakenD=1 in the following RUN cycle -> FlushIFID=1 for 1 cycle.
REQ-032 Reset mid-stall: Reset=1 in the first of 2 stall cycles -> next cycle Cnt=0 and counters 0; after Reset drops with no hazard, PCWriteEn=1.
REQ-033 Counters (HAZARD_PERF_CNT_EN): 3 stall cycles and 2 flush cycles -> StallCount=3, FlushCount=2; saturation test with preload 16'hFFFF -> stays 16'hFFFF.
